// File: rtl/dlfloat_pkg.sv
// rtl/dlfloat_pkg.sv - DLFloat word layout and result transmitter state encoding
package dlfloat_pkg;

  localparam int DLF_W    = 16;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 9;
  localparam int MANT_MSB = 8;
  localparam int MANT_LSB = 0;

  typedef logic [DLF_W-1:0] dlfloat_t;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } tx_state_e;

endpackage

// File: rtl/dlfloat_tx_fifo.sv
// rtl/dlfloat_tx_fifo.sv - synchronous word FIFO with wrap-bit pointers, full/empty and count
module dlfloat_tx_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [AW:0]  fill;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  // Wrap-bit subtraction gives 0..DEPTH directly; CW equals AW+1 for power-of-two depths
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign count_o = CW'(fill);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/dlfloat_result_tx.sv
// rtl/dlfloat_result_tx.sv - buffers 16-bit DLFloat results and serialises them low byte first
module dlfloat_result_tx
  import dlfloat_pkg::*;
#(
  parameter  int WORD_W = 16,
  parameter  int BYTE_W = 8,
  parameter  int DEPTH  = 2,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CW-1:0]     fifo_count
);

  tx_state_e         state_q;
  logic [WORD_W-1:0] shift_q;
  logic [BYTE_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // in_ready looks only at full, so a pop in the same cycle never lets a word slip in
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && ((state_q == IDLE) || (state_q == HI && out_ready));

  dlfloat_tx_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            shift_q     <= head;
            out_data_q  <= head[BYTE_W-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= LO;
          end
        end
        LO: begin
          if (out_ready) begin
            out_data_q <= shift_q[2*BYTE_W-1:BYTE_W];
            out_last_q <= 1'b1;
            state_q    <= HI;
          end
        end
        HI: begin
          if (out_ready) begin
            // Chain straight into the next word so a busy stream has no bubble
            if (!empty) begin
              shift_q     <= head;
              out_data_q  <= head[BYTE_W-1:0];
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              state_q     <= LO;
            end else begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dlfloat_result_tx.sv
// tb/tb_dlfloat_result_tx.sv - self-checking bench for dlfloat_result_tx with queue-based model
module tb_dlfloat_result_tx;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [1:0]  fifo_count;

  always #5 clk = ~clk;

  dlfloat_result_tx #(.WORD_W(16), .BYTE_W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .fifo_count (fifo_count)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: words waiting in a queue, plus the word on the wire and which half is showing
  logic [15:0] m_q[$];
  bit          m_busy = 0;
  bit          m_hi   = 0;
  logic [15:0] m_word = '0;
  bit          m_ok   = 0;
  bit          m_push;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_q.delete();
      m_busy = 0;
      m_hi   = 0;
    end else begin
      m_push = in_valid && (m_q.size() < DEPTH);
      if (!m_busy || (out_ready && m_hi)) begin
        if (m_q.size() > 0) begin
          m_word = m_q.pop_front();
          m_busy = 1;
          m_hi   = 0;
        end else begin
          m_busy = 0;
        end
      end else if (out_ready) begin
        m_hi = 1;
      end
      if (m_push) m_q.push_back(in_data);
    end
    m_ok = 1;
  end

  logic [8:0] byte_log[$];
  int         cyc_log[$];

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      byte_log.push_back({out_last, out_data});
      cyc_log.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (!rst && m_q.size() < DEPTH)});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_busy});
      chk("m_fifo_count", {30'd0, fifo_count}, m_q.size());
      if (m_busy) begin
        chk("m_out_data", {24'd0, out_data}, {24'd0, (m_hi ? m_word[15:8] : m_word[7:0])});
        chk("m_out_last", {31'd0, out_last}, {31'd0, m_hi});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    bit ok;
    ok = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        acc_cyc = cyc + 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic clear_log();
    byte_log.delete();
    cyc_log.delete();
  endtask

  logic [15:0] w[5];
  logic [8:0]  exp_b[$];
  int          n_acc;

  initial begin
    // Reset held for three cycles
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_fifo_count", {30'd0, fifo_count}, 0);
    rst = 1'b0;
    tick();
    chk("release_in_ready", {31'd0, in_ready}, 1);
    chk("release_out_valid", {31'd0, out_valid}, 0);

    // Single word
    clear_log();
    out_ready = 1'b1;
    push_word(16'h3E00);
    repeat (5) tick();
    chk("single_nbytes", byte_log.size(), 2);
    if (byte_log.size() == 2) begin
      chk("single_lo", {23'd0, byte_log[0]}, {23'd0, 9'h000});
      chk("single_hi", {23'd0, byte_log[1]}, {23'd0, 9'h13E});
      chk("single_latency", cyc_log[0], acc_cyc + 1);
      chk("single_gap", cyc_log[1], cyc_log[0] + 1);
    end
    chk("single_idle", {31'd0, out_valid}, 0);

    // Back-to-back words
    clear_log();
    push_word(16'h1234);
    push_word(16'hABCD);
    repeat (6) tick();
    exp_b = '{9'h034, 9'h112, 9'h0CD, 9'h1AB};
    chk("b2b_nbytes", byte_log.size(), 4);
    if (byte_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("b2b_byte", {23'd0, byte_log[i]}, {23'd0, exp_b[i]});
        if (i > 0) chk("b2b_no_bubble", cyc_log[i], cyc_log[i-1] + 1);
      end
    end

    // Backpressure: five offered words, three fit
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
    n_acc = 0;
    for (int c = 0; c < 10 && n_acc < 5; c++) begin
      in_valid = 1'b1;
      in_data  = w[n_acc];
      @(negedge clk);
      if (in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", n_acc, 3);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_fifo_count", {30'd0, fifo_count}, 2);
    chk("bp_hold_data", {24'd0, out_data}, {24'd0, w[0][7:0]});
    out_ready = 1'b1;
    repeat (10) tick();
    chk("bp_nbytes", byte_log.size(), 6);
    if (byte_log.size() == 6) begin
      for (int i = 0; i < 6; i++)
        chk("bp_byte", {23'd0, byte_log[i]},
            {23'd0, (i % 2) ? {1'b1, w[i/2][15:8]} : {1'b0, w[i/2][7:0]}});
    end

    // Full FIFO while the HI beat leaves: no pass-through
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) push_word(w[i]);
    in_valid  = 1'b1;
    in_data   = w[3];
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_lo_in_ready", {31'd0, in_ready}, 0);
    tick();
    @(negedge clk);
    chk("full_hi_in_ready", {31'd0, in_ready}, 0);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("full_after_pop_in_ready", {31'd0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("full_end_count", {30'd0, fifo_count}, DEPTH);
    chk("full_end_in_ready", {31'd0, in_ready}, 0);
    out_ready = 1'b1;
    repeat (12) tick();
    chk("full_nbytes", byte_log.size(), 8);
    if (byte_log.size() == 8) begin
      for (int i = 0; i < 8; i++)
        chk("full_byte", {23'd0, byte_log[i]},
            {23'd0, (i % 2) ? {1'b1, w[i/2][15:8]} : {1'b0, w[i/2][7:0]}});
    end

    // Reset after the low byte of BEEF
    clear_log();
    push_word(16'hBEEF);
    for (int i = 0; i < 10 && byte_log.size() == 0; i++) tick();
    chk("mid_lo_seen", byte_log.size(), 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("mid_post_out_valid", {31'd0, out_valid}, 0);
    chk("mid_post_in_ready", {31'd0, in_ready}, 1);
    push_word(16'h0102);
    repeat (5) tick();
    exp_b = '{9'h0EF, 9'h002, 9'h101};
    chk("mid_nbytes", byte_log.size(), 3);
    if (byte_log.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("mid_byte", {23'd0, byte_log[i]}, {23'd0, exp_b[i]});
    end
    foreach (byte_log[i]) if (byte_log[i] == 9'h1BE) chk("mid_no_be", {23'd0, byte_log[i]}, 0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("drain_out_valid", {31'd0, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
